// File: rtl/cache_set_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with per-set
// LRU replacement, valid/ready CPU handshake, full-cache flush and hit/miss
// performance counters.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/we/addr/wdata    CPU word request (held until req_ready)
//   req_ready, rdata           same-cycle completion and read word
//   flush_req, flush_done      level flush request, one-cycle completion pulse
//   mem_req/we/addr/wblock     block memory request (held until mem_ready)
//   mem_rblock, mem_ready      refill line and one-cycle completion pulse
//   hit_count, miss_count      saturating performance counters
module cache_set_assoc #(
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned ADDR_WIDTH         = 10,
   parameter int unsigned INDEX_WIDTH        = 4,
   parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
   parameter int unsigned WAYS               = 2
) (
   input  logic                                            clk,
   input  logic                                            rstn,
   input  logic                                            req_valid,
   input  logic                                            req_we,
   input  logic [ADDR_WIDTH-1:0]                           req_addr,
   input  logic [DATA_WIDTH-1:0]                           req_wdata,
   output logic                                            req_ready,
   output logic [DATA_WIDTH-1:0]                           rdata,
   input  logic                                            flush_req,
   output logic                                            flush_done,
   output logic                                            mem_req,
   output logic                                            mem_we,
   output logic [ADDR_WIDTH-1:0]                           mem_addr,
   output logic [DATA_WIDTH*(2**BLOCK_OFFSET_WIDTH)-1:0]   mem_wblock,
   input  logic [DATA_WIDTH*(2**BLOCK_OFFSET_WIDTH)-1:0]   mem_rblock,
   input  logic                                            mem_ready,
   output logic [31:0]                                     hit_count,
   output logic [31:0]                                     miss_count
);
   localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
   localparam int unsigned WORDS     = 2 ** BLOCK_OFFSET_WIDTH;
   localparam int unsigned SETS      = 2 ** INDEX_WIDTH;
   localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WAY_W-1:0]       LAST_WAY = WAY_W'(WAYS - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_SET = INDEX_WIDTH'(SETS - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WRITEBACK  = 3'd1;
   localparam logic [2:0] S_REFILL     = 3'd2;
   localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
   localparam logic [2:0] S_FLUSH_WB   = 3'd4;

   logic [2:0]                       r_state, w_state_nxt;
   logic                             r_valid [SETS][WAYS];
   logic                             r_dirty [SETS][WAYS];
   logic [WAY_W-1:0]                 r_age   [SETS][WAYS];
   logic [TAG_WIDTH-1:0]             r_tag   [SETS][WAYS];
   logic [WORDS-1:0][DATA_WIDTH-1:0] r_data  [SETS][WAYS];
   logic                             r_retry, r_flush_done;
   logic [31:0]                      r_hit_count, r_miss_count;
   logic [TAG_WIDTH-1:0]             r_miss_tag;
   logic [INDEX_WIDTH-1:0]           r_miss_idx;
   logic [WAY_W-1:0]                 r_victim;
   logic [INDEX_WIDTH-1:0]           r_scan_set;
   logic [WAY_W-1:0]                 r_scan_way;

   logic [TAG_WIDTH-1:0]          w_tag;
   logic [INDEX_WIDTH-1:0]        w_idx;
   logic [BLOCK_OFFSET_WIDTH-1:0] w_off;
   logic                          w_hit, w_inv_found;
   logic [WAY_W-1:0]              w_hit_way, w_hit_age, w_victim;
   logic                          w_miss, w_flush_start, w_scan_adv, w_flush_fin;
   logic                          w_scan_dirty, w_scan_last;

   assign w_tag        = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign w_idx        = req_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
   assign w_off        = req_addr[BLOCK_OFFSET_WIDTH-1:0];
   assign w_scan_dirty = r_dirty[r_scan_set][r_scan_way];
   assign w_scan_last  = (r_scan_set == LAST_SET) && (r_scan_way == LAST_WAY);
   assign w_hit_age    = r_age[w_idx][w_hit_way];
   assign flush_done   = r_flush_done;
   assign hit_count    = r_hit_count;
   assign miss_count   = r_miss_count;

   // Tag compare across the addressed set and victim choice for a miss
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_victim    = '0;
      w_inv_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (r_age[w_idx][w] == LAST_WAY) w_victim = WAY_W'(w);
      end
      // An empty way always beats the LRU way; lowest index wins
      for (int w = 0; w < WAYS; w++) begin
         if (!w_inv_found && !r_valid[w_idx][w]) begin
            w_inv_found = 1'b1;
            w_victim    = WAY_W'(w);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      w_state_nxt   = r_state;
      req_ready     = 1'b0;
      rdata         = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wblock    = '0;
      w_miss        = 1'b0;
      w_flush_start = 1'b0;
      w_scan_adv    = 1'b0;
      w_flush_fin   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_hit) begin
                  req_ready = 1'b1;
                  rdata     = r_data[w_idx][w_hit_way][w_off];
               end else begin
                  w_miss      = 1'b1;
                  w_state_nxt = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                ? S_WRITEBACK : S_REFILL;
               end
            end else if (flush_req) begin
               w_flush_start = 1'b1;
               w_state_nxt   = S_FLUSH_SCAN;
            end
         end
         S_WRITEBACK: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = {r_tag[r_miss_idx][r_victim], r_miss_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
            mem_wblock = r_data[r_miss_idx][r_victim];
            if (mem_ready) w_state_nxt = S_REFILL;
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {r_miss_tag, r_miss_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
            if (mem_ready) w_state_nxt = S_IDLE;
         end
         S_FLUSH_SCAN: begin
            if (w_scan_dirty) begin
               w_state_nxt = S_FLUSH_WB;
            end else if (w_scan_last) begin
               w_flush_fin = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_scan_adv = 1'b1;
            end
         end
         S_FLUSH_WB: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = {r_tag[r_scan_set][r_scan_way], r_scan_set, {BLOCK_OFFSET_WIDTH{1'b0}}};
            mem_wblock = r_data[r_scan_set][r_scan_way];
            if (mem_ready) begin
               w_flush_fin = w_scan_last;
               w_scan_adv  = !w_scan_last;
               w_state_nxt = w_scan_last ? S_IDLE : S_FLUSH_SCAN;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line status, LRU ages, miss bookkeeping, flush pointer and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w] <= 1'b0;
               r_dirty[s][w] <= 1'b0;
               r_age[s][w]   <= WAY_W'(w);
            end
         end
         r_retry      <= 1'b0;
         r_flush_done <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
         r_miss_tag   <= '0;
         r_miss_idx   <= '0;
         r_victim     <= '0;
         r_scan_set   <= '0;
         r_scan_way   <= '0;
      end else begin
         r_flush_done <= w_flush_fin;
         if (req_ready) begin
            r_retry <= 1'b0;
            if (req_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            if (!r_retry && (r_hit_count != '1)) r_hit_count <= r_hit_count + 32'd1;
            // Promote the accessed way; only ways younger than it age
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == w_hit_way)
                  r_age[w_idx][w] <= '0;
               else if (r_age[w_idx][w] < w_hit_age)
                  r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
            end
         end
         if (w_miss) begin
            r_retry    <= 1'b1;
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_victim   <= w_victim;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
         end
         if ((r_state == S_WRITEBACK) && mem_ready) begin
            r_valid[r_miss_idx][r_victim] <= 1'b0;
            r_dirty[r_miss_idx][r_victim] <= 1'b0;
         end
         if ((r_state == S_REFILL) && mem_ready) begin
            r_valid[r_miss_idx][r_victim] <= 1'b1;
            r_dirty[r_miss_idx][r_victim] <= 1'b0;
         end
         if ((r_state == S_FLUSH_WB) && mem_ready) r_dirty[r_scan_set][r_scan_way] <= 1'b0;
         if (w_flush_start) begin
            r_scan_set <= '0;
            r_scan_way <= '0;
         end else if (w_scan_adv) begin
            if (r_scan_way == LAST_WAY) begin
               r_scan_way <= '0;
               r_scan_set <= r_scan_set + INDEX_WIDTH'(1);
            end else begin
               r_scan_way <= r_scan_way + WAY_W'(1);
            end
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (req_ready && req_we) r_data[w_idx][w_hit_way][w_off] <= req_wdata;
      if ((r_state == S_REFILL) && mem_ready) begin
         r_data[r_miss_idx][r_victim] <= mem_rblock;
         r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
      end
   end
endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc: a line-level cache model with
// timestamp LRU plus a bench-side block memory predict every cycle's outputs.
module tb_cache_set_assoc;
   localparam int DW = 32, AW = 10, IW = 4, BOW = 3, WAYS = 2;
   localparam int SETS = 16, WORDS = 8, LW = 256;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [DW-1:0]   req_wdata = '0;
   logic            req_ready;
   logic [DW-1:0]   rdata;
   logic            flush_req = 1'b0, flush_done;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [LW-1:0]   mem_wblock;
   logic [LW-1:0]   mem_rblock = '0;
   logic            mem_ready = 1'b0;
   logic [31:0]     hit_count, miss_count;

   cache_set_assoc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW),
                     .BLOCK_OFFSET_WIDTH(BOW), .WAYS(WAYS)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rdata(rdata), .flush_req(flush_req), .flush_done(flush_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wblock(mem_wblock), .mem_rblock(mem_rblock), .mem_ready(mem_ready),
      .hit_count(hit_count), .miss_count(miss_count));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // Expected outputs for the current cycle
   logic          exp_ready = 1'b0, exp_rchk = 1'b0, exp_mem_req = 1'b0;
   logic          exp_mem_we = 1'b0, exp_flush_done = 1'b0;
   logic [DW-1:0] exp_rdata = '0;
   logic [AW-1:0] exp_mem_addr = '0;
   logic [LW-1:0] exp_wblock = '0;

   // Cache model and backing memory
   logic                      m_valid [SETS][WAYS];
   logic                      m_dirty [SETS][WAYS];
   logic [2:0]                m_tag   [SETS][WAYS];
   logic [WORDS-1:0][DW-1:0]  m_line  [SETS][WAYS];
   int                        m_stamp [SETS][WAYS];
   int                        m_time;
   logic [31:0]               m_hits, m_misses;
   logic [WORDS-1:0][DW-1:0]  mem [128];

   // Observed DUT events for literal checks
   logic [DW-1:0] last_rdata = '0;
   logic [DW-1:0] last_wb_w2 = '0;
   logic [AW-1:0] wb_addr_q [$];
   int            n_flush_done = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Single compare process, sampled on the falling edge
   always @(negedge clk) begin
      if (req_ready && !req_we) last_rdata = rdata;
      if (mem_req && mem_we && mem_ready) begin
         wb_addr_q.push_back(mem_addr);
         last_wb_w2 = mem_wblock[95:64];
      end
      if (flush_done) n_flush_done++;
      check("req_ready", LW'(req_ready), LW'(exp_ready));
      if (exp_ready && exp_rchk) check("rdata", LW'(rdata), LW'(exp_rdata));
      check("mem_req", LW'(mem_req), LW'(exp_mem_req));
      if (exp_mem_req) begin
         check("mem_we", LW'(mem_we), LW'(exp_mem_we));
         check("mem_addr", LW'(mem_addr), LW'(exp_mem_addr));
         if (exp_mem_we) check("mem_wblock", mem_wblock, exp_wblock);
      end
      check("flush_done", LW'(flush_done), LW'(exp_flush_done));
      check("hit_count", LW'(hit_count), LW'(m_hits));
      check("miss_count", LW'(miss_count), LW'(m_misses));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_stamp[s][w] = -w;
         end
      m_time = 0; m_hits = '0; m_misses = '0;
   endtask

   function automatic int m_lookup(input int s, input logic [2:0] t);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   // Empty way first, otherwise least recently used
   function automatic int m_victim(input int s);
      int v = 0;
      for (int w = 0; w < WAYS; w++)
         if (!m_valid[s][w]) return w;
      for (int w = 1; w < WAYS; w++)
         if (m_stamp[s][w] < m_stamp[s][v]) v = w;
      return v;
   endfunction

   // Memory write: held two cycles, completes on the third
   task automatic mem_wb(input logic [AW-1:0] a, input logic [LW-1:0] line);
      exp_mem_req = 1'b1; exp_mem_we = 1'b1; exp_mem_addr = a; exp_wblock = line;
      tick(); tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem[a[9:3]] = line;
      exp_mem_req = 1'b0;
   endtask

   // Memory read: completes on the second cycle
   task automatic mem_rf(input logic [AW-1:0] a);
      exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = a;
      tick();
      mem_ready = 1'b1; mem_rblock = mem[a[9:3]];
      tick();
      mem_ready = 1'b0; mem_rblock = '1;
      exp_mem_req = 1'b0;
   endtask

   task automatic access(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
      int s, w, v, off;
      logic [2:0] t;
      logic first;
      s = int'(a[6:3]); t = a[9:7]; off = int'(a[2:0]);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      exp_mem_req = 1'b0; exp_flush_done = 1'b0;
      w = m_lookup(s, t);
      first = (w >= 0);
      if (!first) begin
         exp_ready = 1'b0;
         v = m_victim(s);
         tick();
         m_misses++;
         if (m_valid[s][v] && m_dirty[s][v]) begin
            mem_wb({m_tag[s][v], a[6:3], 3'b000}, m_line[s][v]);
            m_valid[s][v] = 1'b0; m_dirty[s][v] = 1'b0;
         end
         mem_rf({t, a[6:3], 3'b000});
         m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_tag[s][v] = t;
         m_line[s][v] = mem[a[9:3]];
         w = v;
      end
      exp_ready = 1'b1; exp_rchk = !we; exp_rdata = m_line[s][w][off];
      tick();
      if (we) begin
         m_line[s][w][off] = wd;
         m_dirty[s][w] = 1'b1;
      end
      m_time++;
      m_stamp[s][w] = m_time;
      if (first) m_hits++;
      req_valid = 1'b0; exp_ready = 1'b0; exp_rchk = 1'b0;
   endtask

   task automatic flush();
      flush_req = 1'b1; exp_ready = 1'b0; exp_mem_req = 1'b0;
      tick();
      flush_req = 1'b0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            exp_mem_req = 1'b0;
            tick();
            if (m_dirty[s][w]) begin
               mem_wb({m_tag[s][w], 4'(s), 3'b000}, m_line[s][w]);
               m_dirty[s][w] = 1'b0;
            end
         end
      exp_flush_done = 1'b1;
      tick();
      exp_flush_done = 1'b0;
   endtask

   logic [AW-1:0] t_addr [8] = '{10'h033, 10'h0B3, 10'h133, 10'h033,
                                 10'h035, 10'h3F8, 10'h3FF, 10'h07F};
   logic          t_we   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [DW-1:0] t_data [8] = '{32'hCAFE0001, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h00000055, 32'h0, 32'h0};

   initial begin
      int v;
      for (int b = 0; b < 128; b++)
         for (int w = 0; w < WORDS; w++)
            mem[b][w] = 32'hA000_0000 + 32'(b * 8 + w);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      tick();

      // Cold miss then hit in the same line
      access(10'h000, 1'b0, '0);
      check("lit_rd_000", LW'(last_rdata), LW'(32'hA000_0000));
      check("lit_miss_1", LW'(miss_count), LW'(32'd1));
      check("lit_hit_0", LW'(hit_count), LW'(32'd0));
      access(10'h001, 1'b0, '0);
      check("lit_rd_001", LW'(last_rdata), LW'(32'hA000_0001));
      check("lit_hit_1", LW'(hit_count), LW'(32'd1));

      // Dirty LRU victim is written back before the refill
      access(10'h002, 1'b1, 32'hDEADBEEF);
      access(10'h080, 1'b0, '0);
      wb_addr_q.delete();
      access(10'h100, 1'b0, '0);
      check("lit_wb_count", LW'(wb_addr_q.size()), LW'(32'd1));
      if (wb_addr_q.size() > 0) check("lit_wb_addr", LW'(wb_addr_q[0]), LW'(10'h000));
      check("lit_wb_word2", LW'(last_wb_w2), LW'(32'hDEADBEEF));
      check("lit_rd_100", LW'(last_rdata), LW'(32'hA000_0100));

      // Clean LRU victim: no write-back
      access(10'h080, 1'b0, '0);
      wb_addr_q.delete();
      access(10'h180, 1'b0, '0);
      check("lit_clean_evict", LW'(wb_addr_q.size()), LW'(32'd0));

      // Flush writes back exactly the two dirty lines
      access(10'h008, 1'b1, 32'h11111111);
      access(10'h010, 1'b1, 32'h22222222);
      wb_addr_q.delete();
      n_flush_done = 0;
      flush();
      check("lit_flush_wbs", LW'(wb_addr_q.size()), LW'(32'd2));
      if (wb_addr_q.size() == 2) begin
         check("lit_flush_a0", LW'(wb_addr_q[0]), LW'(10'h008));
         check("lit_flush_a1", LW'(wb_addr_q[1]), LW'(10'h010));
      end
      check("lit_flush_pulse", LW'(n_flush_done), LW'(32'd1));
      v = int'(hit_count);
      access(10'h008, 1'b0, '0);
      check("lit_rd_008", LW'(last_rdata), LW'(32'h11111111));
      check("lit_post_flush_hit", LW'(hit_count), LW'(v + 1));

      // Mixed traffic on sets 6 and 15
      for (int i = 0; i < 8; i++) access(t_addr[i], t_we[i], t_data[i]);
      access(10'h033, 1'b0, '0);
      check("lit_rd_033", LW'(last_rdata), LW'(32'hCAFE0001));

      // Stray mem_ready in IDLE has no effect
      mem_ready = 1'b1; mem_rblock = '0;
      tick();
      mem_ready = 1'b0;
      tick();

      // Reset while a refill is outstanding
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h200;
      exp_ready = 1'b0; exp_mem_req = 1'b0;
      v = m_victim(0);
      tick();
      m_misses++;
      if (m_valid[0][v] && m_dirty[0][v]) begin
         mem_wb({m_tag[0][v], 4'd0, 3'b000}, m_line[0][v]);
         m_valid[0][v] = 1'b0; m_dirty[0][v] = 1'b0;
      end
      exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = 10'h200;
      tick(); tick();
      rstn = 1'b0;
      model_reset();
      exp_mem_req = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      check("lit_rst_miss", LW'(miss_count), LW'(32'd0));
      access(10'h200, 1'b0, '0);
      check("lit_rst_remiss", LW'(miss_count), LW'(32'd1));
      check("lit_rd_200", LW'(last_rdata), LW'(32'hA000_0200));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
